// File: rtl/button_pulse_gen_if.sv
// button_pulse_gen_if: raw button levels in, press/repeat pulses and debounced levels out
interface button_pulse_gen_if;
  logic [2:0] button_raw;
  logic [2:0] button;
  logic [2:0] stable;
  modport master(output button_raw, input button, input stable);
  modport slave(input button_raw, output button, output stable);
endinterface

// File: rtl/button_pulse_gen.sv
// button_pulse_gen: synchronise, debounce, edge-detect and hold-to-repeat three push buttons
module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_PERIOD = 20000000,
  parameter logic [2:0] REPEAT_MASK = 3'b011
) (
  input logic i_clk,
  input logic i_reset,
  button_pulse_gen_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT} state_t;
  logic [2:0] sync1, sync2;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.button_raw;
      sync2 <= sync1;
    end
  end
  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [DW-1:0] cnt;
    logic stable_q, diff, done, rise, fall;
    state_t state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic pulse_n, pulse_q;
    assign diff = sync2[g] != stable_q;
    assign done = diff && cnt == DW'(DEBOUNCE_CYCLES - 1);
    assign rise = done && sync2[g];
    assign fall = done && !sync2[g];
    // pulse and fsm react to the debounced level that is being committed this edge
    always_comb begin
      state_n = state;
      tmr_n = '0;
      pulse_n = 1'b0;
      if (fall) state_n = IDLE;
      else if (state == IDLE) begin
        pulse_n = rise;
        state_n = rise && REPEAT_MASK[g] ? HOLD_WAIT : IDLE;
      end else if (state == HOLD_WAIT) begin
        pulse_n = tmr == TW'(REPEAT_DELAY - 1);
        state_n = pulse_n ? REPEAT : HOLD_WAIT;
        tmr_n = pulse_n ? '0 : tmr + 1'b1;
      end else begin
        pulse_n = tmr == TW'(REPEAT_PERIOD - 1);
        tmr_n = pulse_n ? '0 : tmr + 1'b1;
      end
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        cnt <= '0;
        stable_q <= 1'b0;
        state <= IDLE;
        tmr <= '0;
        pulse_q <= 1'b0;
      end else begin
        cnt <= diff && !done ? cnt + 1'b1 : '0;
        stable_q <= done ? sync2[g] : stable_q;
        state <= state_n;
        tmr <= tmr_n;
        pulse_q <= pulse_n;
      end
    end
    assign bus.stable[g] = stable_q;
    assign bus.button[g] = pulse_q;
  end
endmodule
